// File: rtl/dbram_port_arbiter.sv
// Shares the single-ported data BRAM between the core dbram path and a
// secondary burst-capable requester; read data returns to its owner one cycle later.
module dbram_port_arbiter #(
  parameter int ADDR_W       = 10,
  parameter int DATA_W       = 32,
  parameter int STARVE_LIMIT = 4,
  parameter int MAX_BURST    = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                c_req,
  output logic                c_ready,
  input  logic [ADDR_W-1:0]   c_addr,
  input  logic [DATA_W/8-1:0] c_be,
  input  logic [DATA_W-1:0]   c_wdata,
  output logic [DATA_W-1:0]   c_rdata,
  output logic                c_rvalid,
  input  logic                s_req,
  input  logic                s_lock,
  output logic                s_ready,
  input  logic [ADDR_W-1:0]   s_addr,
  input  logic [DATA_W/8-1:0] s_be,
  input  logic [DATA_W-1:0]   s_wdata,
  output logic [DATA_W-1:0]   s_rdata,
  output logic                s_rvalid,
  output logic                mem_en,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W/8-1:0] mem_be,
  output logic [DATA_W-1:0]   mem_wdata,
  input  logic [DATA_W-1:0]   mem_rdata,
  output logic                in_burst
);

  localparam int SC_W = $clog2(STARVE_LIMIT + 1);
  localparam int BC_W = $clog2(MAX_BURST + 1);

  typedef enum logic {ARB, BURST} state_t;

  state_t          state;
  logic [SC_W-1:0] starve_cnt;
  logic [BC_W-1:0] beat_cnt;
  logic            rd_c;
  logic            rd_s;
  logic            starved;
  logic            last_beat;
  logic            burst_exit;

  assign starved   = starve_cnt == SC_W'(STARVE_LIMIT);
  assign last_beat = beat_cnt == BC_W'(MAX_BURST - 1);

  // Grants are held off while rst_n is low so every output reads 0 in reset
  always_comb begin
    c_ready = 1'b0;
    s_ready = 1'b0;
    if (rst_n) begin
      unique case (state)
        ARB: begin
          c_ready = c_req & ~(s_req & starved);
          s_ready = s_req & (~c_req | starved);
        end
        BURST: s_ready = s_req;
        default: ;
      endcase
    end
  end

  always_comb begin
    mem_addr  = '0;
    mem_be    = '0;
    mem_wdata = '0;
    unique case (1'b1)
      c_ready: begin
        mem_addr  = c_addr;
        mem_be    = c_be;
        mem_wdata = c_wdata;
      end
      s_ready: begin
        mem_addr  = s_addr;
        mem_be    = s_be;
        mem_wdata = s_wdata;
      end
      default: ;
    endcase
  end

  assign mem_en   = c_ready | s_ready;
  assign c_rvalid = rd_c;
  assign s_rvalid = rd_s;
  assign c_rdata  = rd_c ? mem_rdata : '0;
  assign s_rdata  = rd_s ? mem_rdata : '0;
  assign in_burst = state == BURST;

  assign burst_exit = (s_ready & (~s_lock | last_beat))
                    | (~s_req & ~s_lock);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ARB;
      starve_cnt <= '0;
      beat_cnt   <= '0;
      rd_c       <= 1'b0;
      rd_s       <= 1'b0;
    end else begin
      rd_c <= c_ready & ~|c_be;
      rd_s <= s_ready & ~|s_be;
      if (c_ready & s_req)
        starve_cnt <= starved ? starve_cnt : starve_cnt + 1'b1;
      else
        starve_cnt <= '0;
      unique case (state)
        ARB: begin
          if (s_ready & s_lock) begin
            state    <= BURST;
            beat_cnt <= BC_W'(1);
          end
        end
        BURST: begin
          if (burst_exit) begin
            state    <= ARB;
            beat_cnt <= '0;
          end else if (s_ready) begin
            beat_cnt <= beat_cnt + 1'b1;
          end
        end
        default: state <= ARB;
      endcase
    end
  end

endmodule

// File: tb/tb_dbram_port_arbiter.sv
// Scoreboard bench for dbram_port_arbiter with a behavioural BRAM
// and a reference memory image kept from driven stimulus.
module tb_dbram_port_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        c_req, c_ready, c_rvalid;
  logic [9:0]  c_addr;
  logic [3:0]  c_be;
  logic [31:0] c_wdata, c_rdata;
  logic        s_req, s_lock, s_ready, s_rvalid;
  logic [9:0]  s_addr;
  logic [3:0]  s_be;
  logic [31:0] s_wdata, s_rdata;
  logic        mem_en, in_burst;
  logic [9:0]  mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata = '0;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  typedef struct {
    int          due;
    logic [31:0] d;
  } exp_t;

  exp_t        cq[$];
  exp_t        sq[$];
  logic [31:0] bram_w[int];
  logic [31:0] ref_w[int];

  dbram_port_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .c_req(c_req), .c_ready(c_ready), .c_addr(c_addr), .c_be(c_be),
    .c_wdata(c_wdata), .c_rdata(c_rdata), .c_rvalid(c_rvalid),
    .s_req(s_req), .s_lock(s_lock), .s_ready(s_ready), .s_addr(s_addr),
    .s_be(s_be), .s_wdata(s_wdata), .s_rdata(s_rdata), .s_rvalid(s_rvalid),
    .mem_en(mem_en), .mem_addr(mem_addr), .mem_be(mem_be),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .in_burst(in_burst)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] pat(input logic [9:0] a);
    return {a[7:0] ^ 8'h5A, 8'hC3, a[7:0], 6'h0F, a[9:8]};
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old,
                                        input logic [3:0] be,
                                        input logic [31:0] wd);
    logic [31:0] w;
    w = old;
    for (int b = 0; b < 4; b++)
      if (be[b]) w[8*b +: 8] = wd[8*b +: 8];
    return w;
  endfunction

  function automatic logic [31:0] bram_rd(input logic [9:0] a);
    return bram_w.exists(int'(a)) ? bram_w[int'(a)] : pat(a);
  endfunction

  function automatic logic [31:0] ref_rd(input logic [9:0] a);
    return ref_w.exists(int'(a)) ? ref_w[int'(a)] : pat(a);
  endfunction

  // Behavioural single-port BRAM, 1-cycle read latency
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_be == 4'h0)
        mem_rdata <= bram_rd(mem_addr);
      else
        bram_w[int'(mem_addr)] = merge(bram_rd(mem_addr), mem_be, mem_wdata);
    end
  end

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (cq.size() > 0 && cq[0].due == cyc) begin
      chk("c_rvalid", 64'(c_rvalid), 64'(1));
      chk("c_rdata", 64'(c_rdata), 64'(cq[0].d));
      void'(cq.pop_front());
    end else begin
      chk("c_rvalid_idle", 64'(c_rvalid), 64'(0));
    end
    if (sq.size() > 0 && sq[0].due == cyc) begin
      chk("s_rvalid", 64'(s_rvalid), 64'(1));
      chk("s_rdata", 64'(s_rdata), 64'(sq[0].d));
      void'(sq.pop_front());
    end else begin
      chk("s_rvalid_idle", 64'(s_rvalid), 64'(0));
    end
  end

  // g: 0 no grant, 1 core, 2 secondary; b: expected in_burst
  task automatic tick(input int g, input bit b, input string tag);
    logic [9:0]  ea;
    logic [3:0]  eb;
    logic [31:0] ew;
    @(negedge clk);
    ea = '0;
    eb = '0;
    ew = '0;
    if (g == 1) begin
      ea = c_addr; eb = c_be; ew = c_wdata;
    end else if (g == 2) begin
      ea = s_addr; eb = s_be; ew = s_wdata;
    end
    chk({tag, ".c_ready"}, 64'(c_ready), 64'(g == 1));
    chk({tag, ".s_ready"}, 64'(s_ready), 64'(g == 2));
    chk({tag, ".mem_en"}, 64'(mem_en), 64'(g != 0));
    chk({tag, ".mem_be"}, 64'(mem_be), 64'(eb));
    chk({tag, ".in_burst"}, 64'(in_burst), 64'(b));
    if (g != 0) begin
      chk({tag, ".mem_addr"}, 64'(mem_addr), 64'(ea));
      if (eb == 4'h0) begin
        if (g == 1) cq.push_back('{cyc + 1, ref_rd(ea)});
        else        sq.push_back('{cyc + 1, ref_rd(ea)});
      end else begin
        chk({tag, ".mem_wdata"}, 64'(mem_wdata), 64'(ew));
        ref_w[int'(ea)] = merge(ref_rd(ea), eb, ew);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic rst_chk(input string tag);
    @(negedge clk);
    chk({tag, ".ctl"}, 64'({c_ready, s_ready, c_rvalid, s_rvalid,
                            mem_en, in_burst, mem_be}), 64'(0));
    chk({tag, ".addr"}, 64'(mem_addr), 64'(0));
    chk({tag, ".wdata"}, 64'(mem_wdata), 64'(0));
    chk({tag, ".rdata"}, {c_rdata, s_rdata}, 64'(0));
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b1;
    {c_req, s_req, s_lock} = '0;
    c_addr = '0; c_be = '0; c_wdata = '0;
    s_addr = '0; s_be = '0; s_wdata = '0;
    #1 rst_n = 1'b0;
    c_req = 1'b1; s_req = 1'b1; c_addr = 10'h3FF; s_addr = 10'h155;
    c_wdata = 32'hFFFF_FFFF; s_wdata = 32'h1234_5678; c_be = 4'hF;
    rst_chk("rst0");
    rst_n = 1'b1;
    {c_req, s_req, s_lock} = '0;
    c_be = '0;

    c_req = 1'b1; c_addr = 10'h010;
    tick(1, 0, "core_rd");
    c_req = 1'b0;
    tick(0, 0, "idle0");

    for (int i = 0; i < 10; i++) begin
      c_req = 1'b1; s_req = 1'b1; s_lock = 1'b0;
      c_be = '0; s_be = '0;
      c_addr = 10'(10'h020 + i); s_addr = 10'(10'h040 + i);
      tick((i % 5 == 4) ? 2 : 1, 0, $sformatf("starve%0d", i));
    end
    c_req = 1'b0; s_req = 1'b0;
    tick(0, 0, "idle1");

    for (int i = 0; i < 12; i++) begin
      s_req = 1'b1; s_lock = (i != 11); s_be = 4'hF;
      s_addr = 10'(10'h100 + i); s_wdata = 32'hBEEF_0000 + i;
      if (i == 8) begin
        c_req = 1'b1; c_be = '0; c_addr = 10'h103;
        tick(1, 0, "post_force");
        c_req = 1'b0;
      end
      tick(2, (i != 0 && i != 8), $sformatf("burst%0d", i));
    end
    s_req = 1'b0; s_lock = 1'b0;
    tick(0, 0, "burst_done");

    c_req = 1'b1; c_be = 4'b0101; c_addr = 10'h010; c_wdata = 32'h1122_3344;
    tick(1, 0, "core_bewr");
    c_be = '0; c_addr = 10'h10A;
    tick(1, 0, "core_rdN");
    c_req = 1'b0;
    s_req = 1'b1; s_be = '0; s_addr = 10'h010;
    tick(2, 0, "sec_rdN1");
    s_req = 1'b0;
    tick(0, 0, "idle2");

    s_req = 1'b1; s_lock = 1'b1; s_be = '0; s_addr = 10'h050;
    tick(2, 0, "lock0");
    s_addr = 10'h051;
    tick(2, 1, "lock1");
    s_req = 1'b0; s_lock = 1'b0;
    c_req = 1'b1; c_be = '0; c_addr = 10'h060;
    tick(0, 1, "drop");
    tick(1, 0, "drop_core");
    c_req = 1'b0;
    tick(0, 0, "idle3");

    c_req = 1'b1; c_be = '0; c_addr = 10'h070;
    tick(1, 0, "pre_rst");
    rst_n = 1'b0;
    cq.delete();
    sq.delete();
    s_req = 1'b1; s_lock = 1'b1; s_addr = 10'h0AA;
    rst_chk("rst1");
    rst_n = 1'b1;
    s_req = 1'b0; s_lock = 1'b0;
    c_addr = 10'h071;
    tick(1, 0, "post_rst");
    c_req = 1'b0;
    tick(0, 0, "idle4");
    tick(0, 0, "idle5");

    chk("sb_drain", 64'(cq.size() + sq.size()), 64'(0));
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
